// File: rtl/jtopl_mixacc_pkg.sv
// Shared widths and slot/channel mapping for the OPL operator mix accumulator.
package jtopl_mixacc_pkg;
    localparam int OPW   = 13;
    localparam int ACCW  = 18;
    localparam int SNDW  = 16;
    localparam int SLOTS = 18;
    localparam int NCH   = 9;

    // Slots s and s+3 of each 6-slot group belong to the same channel
    function automatic logic [3:0] slot_ch(input logic [4:0] s);
        logic [4:0] grp;
        logic [4:0] sub;
        logic [4:0] ch;
        grp = s / 5'd6;
        sub = s % 5'd3;
        ch  = grp * 5'd3 + sub;
        return ch[3:0];
    endfunction
endpackage

// File: rtl/jtopl_sat.sv
// Combinational signed saturation from IW bits down to OW bits.
module jtopl_sat #(
    parameter int IW = 18,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);
    logic [IW-OW:0] top;

    // In range only when every bit above the output sign bit matches it
    assign top  = din[IW-1:OW-1];
    assign ovf  = !((&top) || (~|top));
    assign dout = !ovf     ? din[OW-1:0] :
                  din[IW-1] ? {1'b1, {(OW-1){1'b0}}} :
                              {1'b0, {(OW-1){1'b1}}};
endmodule

// File: rtl/jtopl_mixacc.sv
// Sums audible operator outputs over an 18-slot frame and latches a saturated sample.
module jtopl_mixacc
    import jtopl_mixacc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cenop,
    input  logic                   zero,
    input  logic signed [OPW-1:0]  op_result,
    input  logic                   op_out,
    input  logic                   con_out,
    input  logic [NCH-1:0]         mute,
    output logic signed [SNDW-1:0] snd,
    output logic                   sample,
    output logic                   clip
);
    logic [4:0]             cnt;
    logic [4:0]             slot;
    logic [3:0]             ch;
    logic [NCH-1:0]         ch_mask;
    logic                   muted;
    logic signed [OPW-1:0]  contrib;
    logic signed [ACCW-1:0] contrib_ext;
    logic signed [ACCW-1:0] acc;
    logic signed [SNDW-1:0] sat_out;
    logic                   sat_ovf;

    assign slot    = zero ? 5'd0 : cnt;
    assign ch      = slot_ch(slot);
    assign ch_mask = NCH'(1) << ch;
    assign muted   = |(mute & ch_mask);

    // Modulators are heard only in additive connection
    assign contrib     = muted                ? '0        :
                         (op_out || con_out)  ? op_result : '0;
    assign contrib_ext = ACCW'(contrib);

    jtopl_sat #(.IW(ACCW), .OW(SNDW)) u_sat (
        .din  (acc),
        .dout (sat_out),
        .ovf  (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            snd    <= '0;
            clip   <= 1'b0;
            sample <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (cenop) begin
                if (zero) begin
                    // Close the frame; slot 0 starts the next sum
                    cnt    <= 5'd1;
                    snd    <= sat_out;
                    clip   <= sat_ovf;
                    acc    <= contrib_ext;
                    sample <= 1'b1;
                end else begin
                    cnt <= (cnt == 5'(SLOTS-1)) ? 5'd0 : cnt + 5'd1;
                    acc <= acc + contrib_ext;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtopl_mixacc.sv
// Directed frames with a scoreboard of expected samples, checked when sample strobes.
module tb_jtopl_mixacc;
    import jtopl_mixacc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, cenop, zero, op_out, con_out;
    logic signed [OPW-1:0]  op_result;
    logic [NCH-1:0]         mute;
    logic signed [SNDW-1:0] snd;
    logic                   sample, clip;

    typedef struct packed {
        logic signed [SNDW-1:0] snd;
        logic                   clip;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   n_samp = 0;
    int   n_push = 0;
    int   samp_before;

    always #5 clk = ~clk;

    jtopl_mixacc dut (
        .clk       (clk),
        .rst       (rst),
        .cenop     (cenop),
        .zero      (zero),
        .op_result (op_result),
        .op_out    (op_out),
        .con_out   (con_out),
        .mute      (mute),
        .snd       (snd),
        .sample    (sample),
        .clip      (clip)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Every sample strobe must match the oldest expected frame result
    always @(negedge clk) begin
        if (sample === 1'b1) begin : mon
            exp_t e;
            n_samp++;
            if (sb.size() == 0) begin
                chk("unexpected_sample", 32'(sample), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("snd", 32'(snd), 32'(e.snd));
                chk("clip", 32'(clip), 32'(e.clip));
            end
        end
    end

    task automatic slot(input bit z, input int s, input int car, input int mod, input bit co);
        zero      = z;
        op_out    = (s % 6) >= 3;
        op_result = OPW'(op_out ? car : mod);
        con_out   = co;
        cenop     = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic close_frame();
        sb.push_back(pend);
        n_push++;
    endtask

    task automatic set_pend(input int s, input bit c);
        pend.snd  = SNDW'(s);
        pend.clip = c;
    endtask

    task automatic frame(input int car, input int mod, input bit co, input int es, input bit ec);
        close_frame();
        for (int s = 0; s < SLOTS; s++) slot(s == 0, s, car, mod, co);
        set_pend(es, ec);
    endtask

    initial begin
        rst = 1'b1; cenop = 1'b0; zero = 1'b0; op_result = '0;
        op_out = 1'b0; con_out = 1'b0; mute = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_snd", 32'(snd), 32'(0));
        chk("rst_sample", 32'(sample), 32'(0));
        chk("rst_clip", 32'(clip), 32'(0));
        rst = 1'b0;
        set_pend(0, 1'b0);

        frame(1000, 5000, 1'b0, 9000, 1'b0);
        frame(4095, 4095, 1'b1, 32767, 1'b1);
        frame(-4096, -4096, 1'b1, -32768, 1'b1);
        mute = 9'h001;
        frame(100, 5000, 1'b0, 800, 1'b0);
        mute = '0;

        // Early zero after slot 4: only carriers 3 and 4 counted
        close_frame();
        for (int s = 0; s < 5; s++) slot(s == 0, s, 10, 7, 1'b0);
        set_pend(20, 1'b0);
        chk("cnt_before_early", 32'(dut.cnt), 32'(5));
        close_frame();
        slot(1'b1, 0, 200, 50, 1'b0);
        chk("cnt_resync", 32'(dut.cnt), 32'(1));

        // Reset at slot 9 drops the partial sum of slots 0..8
        for (int s = 1; s < 9; s++) slot(1'b0, s, 200, 50, 1'b0);
        rst = 1'b1; cenop = 1'b1; zero = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; cenop = 1'b0;
        chk("midrst_snd", 32'(snd), 32'(0));
        chk("midrst_sample", 32'(sample), 32'(0));
        chk("midrst_clip", 32'(clip), 32'(0));
        chk("midrst_acc", 32'(dut.acc), 32'(0));
        for (int s = 9; s < SLOTS; s++) slot(1'b0, s, 200, 50, 1'b0);
        set_pend(1200, 1'b0);

        // cenop stall mid-frame must freeze everything
        close_frame();
        for (int s = 0; s < 9; s++) slot(s == 0, s, 300, 50, 1'b0);
        cenop = 1'b0;
        samp_before = n_samp;
        repeat (100) @(posedge clk);
        #1;
        chk("hold_snd", 32'(snd), 32'(1200));
        chk("hold_clip", 32'(clip), 32'(0));
        chk("hold_samples", n_samp, samp_before);
        for (int s = 9; s < SLOTS; s++) slot(1'b0, s, 300, 50, 1'b0);
        set_pend(2700, 1'b0);
        close_frame();
        slot(1'b1, 0, 0, 0, 1'b0);
        cenop = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        chk("sample_count", n_samp, n_push);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
